// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart core transmitter between NUM_REQ byte-stream requesters.
//   Round-robin grant, held for a whole packet (until REQ_LAST). Each byte is
//   handed to the core with a one-cycle TX_DRDY strobe, then the arbiter waits
//   for TX_DONE. A watchdog releases an owner that stalls or a core that never
//   answers.
//
// Ports
//   CLK, RST      clock, synchronous active-high reset
//   REQ_VALID     per-requester byte valid
//   REQ_DATA      flattened bytes, req i at [i*DATA_BITS +: DATA_BITS]
//   REQ_LAST      per-requester last-byte-of-packet flag
//   REQ_READY     per-requester accept (only asserted in ACCEPT)
//   GRANT         one-hot current owner, 0 when idle
//   TX_DRDY       one-cycle load strobe to the uart core
//   TX_DI         byte to the uart core, held from TX_DRDY until the next load
//   TX_DONE       one-cycle pulse from the core at end of stop bit
//   BUSY          arbiter not idle
//   TIMEOUT_ERR   one-cycle pulse when the watchdog forces a release
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_BITS      = 8,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic [NUM_REQ-1:0]             REQ_VALID,
   input  logic [NUM_REQ*DATA_BITS-1:0]   REQ_DATA,
   input  logic [NUM_REQ-1:0]             REQ_LAST,
   output logic [NUM_REQ-1:0]             REQ_READY,
   output logic [NUM_REQ-1:0]             GRANT,
   output logic                           TX_DRDY,
   output logic [DATA_BITS-1:0]           TX_DI,
   input  logic                           TX_DONE,
   output logic                           BUSY,
   output logic                           TIMEOUT_ERR
);

   localparam int IW         = $clog2(NUM_REQ);
   localparam bit WD_EN      = (TIMEOUT_CYCLES > 0);
   localparam int CW         = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int WD_LIMIT_I = WD_EN ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CW-1:0] WD_LIMIT = CW'(WD_LIMIT_I);

   typedef enum logic [1:0] {ST_IDLE, ST_ACCEPT, ST_WAIT} state_t;

   state_t                 state_q, state_d;
   logic [IW-1:0]          owner_q, owner_d;
   logic [IW-1:0]          last_owner_q, last_owner_d;
   logic [NUM_REQ-1:0]     grant_q, grant_d;
   logic                   last_q, last_d;
   logic [DATA_BITS-1:0]   di_q, di_d;
   logic                   drdy_q, drdy_d;
   logic                   terr_q, terr_d;
   logic [CW-1:0]          wd_q, wd_d;

   // Packed view of the flattened request bytes; layout is identical.
   logic [NUM_REQ-1:0][DATA_BITS-1:0] req_bytes;
   assign req_bytes = REQ_DATA;

   function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int off);
      return IW'((int'(base) + off) % NUM_REQ);
   endfunction

   // Round-robin pick: first valid requester after last_owner, wrapping.
   logic          found;
   logic [IW-1:0] pick;
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         if (!found && REQ_VALID[rr_idx(last_owner_q, i)]) begin
            found = 1'b1;
            pick  = rr_idx(last_owner_q, i);
         end
      end
   end

   logic wd_fire;
   assign wd_fire = WD_EN && (wd_q == WD_LIMIT);

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      grant_d      = grant_q;
      last_d       = last_q;
      di_d         = di_q;
      drdy_d       = 1'b0;
      terr_d       = 1'b0;
      wd_d         = WD_EN ? wd_q + CW'(1) : '0;
      case (state_q)
         ST_IDLE: begin
            wd_d = '0;
            if (found) begin
               owner_d       = pick;
               grant_d       = '0;
               grant_d[pick] = 1'b1;
               state_d       = ST_ACCEPT;
            end
         end
         ST_ACCEPT: begin
            // A handshake on the cycle the watchdog expires still counts as progress.
            if (REQ_VALID[owner_q]) begin
               di_d    = req_bytes[owner_q];
               last_d  = REQ_LAST[owner_q];
               drdy_d  = 1'b1;
               wd_d    = '0;
               state_d = ST_WAIT;
            end else if (wd_fire) begin
               terr_d       = 1'b1;
               grant_d      = '0;
               last_owner_d = owner_q;
               wd_d         = '0;
               state_d      = ST_IDLE;
            end
         end
         ST_WAIT: begin
            // drdy_q marks the first WAIT cycle; a TX_DONE there belongs to the previous byte.
            if (TX_DONE && !drdy_q) begin
               wd_d = '0;
               if (last_q) begin
                  grant_d      = '0;
                  last_owner_d = owner_q;
                  state_d      = ST_IDLE;
               end else begin
                  state_d = ST_ACCEPT;
               end
            end else if (wd_fire) begin
               terr_d       = 1'b1;
               grant_d      = '0;
               last_owner_d = owner_q;
               wd_d         = '0;
               state_d      = ST_IDLE;
            end
         end
         default: begin
            grant_d = '0;
            wd_d    = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= ST_IDLE;
         owner_q      <= '0;
         last_owner_q <= IW'(NUM_REQ - 1);
         grant_q      <= '0;
         last_q       <= 1'b0;
         di_q         <= '0;
         drdy_q       <= 1'b0;
         terr_q       <= 1'b0;
         wd_q         <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         grant_q      <= grant_d;
         last_q       <= last_d;
         di_q         <= di_d;
         drdy_q       <= drdy_d;
         terr_q       <= terr_d;
         wd_q         <= wd_d;
      end
   end

   assign REQ_READY   = (state_q == ST_ACCEPT) ? grant_q : '0;
   assign GRANT       = grant_q;
   assign TX_DRDY     = drdy_q;
   assign TX_DI       = di_q;
   assign BUSY        = (state_q != ST_IDLE);
   assign TIMEOUT_ERR = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a table of per-cycle vectors for round-robin
// service, plus hand sequences for packet lock, watchdog, stall and reset.
// Cycle k is the interval after the k-th rising edge following reset release;
// outputs are sampled 1 ns after the edge, inputs driven right after.
module tb_uart_tx_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic [3:0]  REQ_VALID;
   logic [31:0] REQ_DATA;
   logic [3:0]  REQ_LAST;
   logic        TX_DONE;
   logic [3:0]  REQ_READY, GRANT;
   logic        TX_DRDY, BUSY, TIMEOUT_ERR;
   logic [7:0]  TX_DI;

   // Second instance with a short watchdog, driven by the same stimulus.
   logic [3:0]  w_ready, w_grant;
   logic        w_drdy, w_busy, w_terr;
   logic [7:0]  w_di;

   always #5 CLK = ~CLK;

   uart_tx_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .TIMEOUT_CYCLES(4096)) dut (
      .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA),
      .REQ_LAST(REQ_LAST), .REQ_READY(REQ_READY), .GRANT(GRANT),
      .TX_DRDY(TX_DRDY), .TX_DI(TX_DI), .TX_DONE(TX_DONE), .BUSY(BUSY),
      .TIMEOUT_ERR(TIMEOUT_ERR));

   uart_tx_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .TIMEOUT_CYCLES(16)) dut_wd (
      .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA),
      .REQ_LAST(REQ_LAST), .REQ_READY(w_ready), .GRANT(w_grant),
      .TX_DRDY(w_drdy), .TX_DI(w_di), .TX_DONE(TX_DONE), .BUSY(w_busy),
      .TIMEOUT_ERR(w_terr));

   typedef struct packed {
      logic [3:0] valid;
      logic       done;
      logic [3:0] grant;
      logic [3:0] ready;
      logic       drdy;
      logic [7:0] di;
      logic       busy;
   } vec_t;

   vec_t tv [22];
   int   n_vec = 0;
   int   n_bad = 0;
   int   plen [4];
   int   sent [4];
   logic [3:0] g_log [$];
   logic [7:0] d_log [$];

   function automatic vec_t mk(input logic [3:0] v, input logic d, input logic [3:0] g,
                               input logic [3:0] r, input logic dr, input logic [7:0] di,
                               input logic b);
      vec_t t;
      t.valid = v; t.done = d; t.grant = g; t.ready = r; t.drdy = dr; t.di = di; t.busy = b;
      return t;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [3:0] g, input logic [3:0] r,
                            input logic dr, input logic [7:0] di, input logic b,
                            input logic te);
      chk({tag, "_grant"}, 32'(GRANT), 32'(g));
      chk({tag, "_ready"}, 32'(REQ_READY), 32'(r));
      chk({tag, "_drdy"},  32'(TX_DRDY), 32'(dr));
      chk({tag, "_di"},    32'(TX_DI), 32'(di));
      chk({tag, "_busy"},  32'(BUSY), 32'(b));
      chk({tag, "_terr"},  32'(TIMEOUT_ERR), 32'(te));
   endtask

   task automatic do_reset();
      RST = 1'b1; REQ_VALID = '0; REQ_DATA = '0; REQ_LAST = '0; TX_DONE = 1'b0;
      tick();
      tick();
      RST = 1'b0;
   endtask

   // Requesters stream plen[i] bytes (0xA0 + 16*i + k); core answers TX_DONE
   // two cycles after each TX_DRDY. Every strobe is logged with its grant.
   task automatic run_traffic(input int ncyc);
      int dcnt = 0;
      logic [3:0] rdy;
      logic [7:0] b;
      for (int c = 0; c < ncyc; c++) begin
         for (int i = 0; i < 4; i++) begin
            b = 8'(8'hA0 + i * 16 + sent[i]);
            REQ_VALID[i]       = (sent[i] < plen[i]);
            REQ_LAST[i]        = (sent[i] == plen[i] - 1);
            REQ_DATA[i*8 +: 8] = b;
         end
         TX_DONE = (dcnt == 1);
         if (dcnt > 0) dcnt--;
         rdy = REQ_READY;
         tick();
         for (int i = 0; i < 4; i++)
            if (rdy[i] && REQ_VALID[i]) sent[i]++;
         if (TX_DRDY) begin
            g_log.push_back(GRANT);
            d_log.push_back(TX_DI);
            dcnt = 3;
         end
      end
      TX_DONE = 1'b0; REQ_VALID = '0; REQ_LAST = '0;
   endtask

   initial begin
      // Round-robin table: all four valid with 1-byte packets. A release goes
      // through one IDLE cycle, so the next strobe is 3 cycles after TX_DONE.
      // Row 2 TX_DONE coincides with TX_DRDY (stale); rows 9/10 land in IDLE/ACCEPT.
      tv[0]  = mk(4'hF, 0, 4'h0, 4'h0, 0, 8'h00, 0);
      tv[1]  = mk(4'hF, 0, 4'h1, 4'h1, 0, 8'h00, 1);
      tv[2]  = mk(4'hF, 1, 4'h1, 4'h0, 1, 8'h10, 1);
      tv[3]  = mk(4'hF, 0, 4'h1, 4'h0, 0, 8'h10, 1);
      tv[4]  = mk(4'hF, 1, 4'h1, 4'h0, 0, 8'h10, 1);
      tv[5]  = mk(4'hF, 0, 4'h0, 4'h0, 0, 8'h10, 0);
      tv[6]  = mk(4'hF, 0, 4'h2, 4'h2, 0, 8'h10, 1);
      tv[7]  = mk(4'hF, 0, 4'h2, 4'h0, 1, 8'h11, 1);
      tv[8]  = mk(4'hF, 1, 4'h2, 4'h0, 0, 8'h11, 1);
      tv[9]  = mk(4'hF, 1, 4'h0, 4'h0, 0, 8'h11, 0);
      tv[10] = mk(4'hF, 1, 4'h4, 4'h4, 0, 8'h11, 1);
      tv[11] = mk(4'hF, 0, 4'h4, 4'h0, 1, 8'h12, 1);
      tv[12] = mk(4'hF, 1, 4'h4, 4'h0, 0, 8'h12, 1);
      tv[13] = mk(4'hF, 0, 4'h0, 4'h0, 0, 8'h12, 0);
      tv[14] = mk(4'hF, 0, 4'h8, 4'h8, 0, 8'h12, 1);
      tv[15] = mk(4'hF, 0, 4'h8, 4'h0, 1, 8'h13, 1);
      tv[16] = mk(4'hF, 1, 4'h8, 4'h0, 0, 8'h13, 1);
      tv[17] = mk(4'hF, 0, 4'h0, 4'h0, 0, 8'h13, 0);
      tv[18] = mk(4'hF, 0, 4'h1, 4'h1, 0, 8'h13, 1);
      tv[19] = mk(4'h0, 0, 4'h1, 4'h0, 1, 8'h10, 1);
      tv[20] = mk(4'h0, 1, 4'h1, 4'h0, 0, 8'h10, 1);
      tv[21] = mk(4'h0, 0, 4'h0, 4'h0, 0, 8'h10, 0);

      // 1: single byte A5 from req0, TX_DONE at c20
      do_reset();
      check_all("t1_reset", 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0);
      REQ_VALID = 4'b0001; REQ_DATA = 32'h0000_00A5; REQ_LAST = 4'b0001;
      tick();                                         // c1
      chk("t1_c1_grant", 32'(GRANT), 32'h1);
      chk("t1_c1_ready", 32'(REQ_READY), 32'h1);
      chk("t1_c1_drdy", 32'(TX_DRDY), 32'h0);
      tick();                                         // c2
      chk("t1_c2_drdy", 32'(TX_DRDY), 32'h1);
      chk("t1_c2_di", 32'(TX_DI), 32'hA5);
      chk("t1_c2_ready", 32'(REQ_READY), 32'h0);
      REQ_VALID = '0;
      repeat (17) tick();                             // c19
      chk("t1_c19_grant", 32'(GRANT), 32'h1);
      chk("t1_c19_busy", 32'(BUSY), 32'h1);
      chk("t1_c19_drdy", 32'(TX_DRDY), 32'h0);
      tick();                                         // c20
      TX_DONE = 1'b1;
      tick();                                         // c21
      TX_DONE = 1'b0;
      check_all("t1_c21", 4'h0, 4'h0, 1'b0, 8'hA5, 1'b0, 1'b0);

      // 2: req0 and req2 each send 3 bytes concurrently, no interleave
      do_reset();
      plen = '{3, 0, 3, 0};
      sent = '{0, 0, 0, 0};
      run_traffic(40);
      chk("t2_count", 32'(g_log.size()), 32'd6);
      for (int k = 0; k < 6 && k < g_log.size(); k++) begin
         chk($sformatf("t2_grant%0d", k), 32'(g_log[k]), (k < 3) ? 32'h1 : 32'h4);
         chk($sformatf("t2_byte%0d", k), 32'(d_log[k]), (k < 3) ? 32'hA0 + 32'(k) : 32'hC0 + 32'(k - 3));
      end
      chk("t2_idle", 32'(BUSY), 32'h0);

      // 3: round-robin table
      do_reset();
      REQ_DATA = 32'h1312_1110; REQ_LAST = 4'hF;
      for (int k = 0; k < 22; k++) begin
         check_all($sformatf("t3_row%0d", k), tv[k].grant, tv[k].ready, tv[k].drdy,
                   tv[k].di, tv[k].busy, 1'b0);
         REQ_VALID = tv[k].valid;
         TX_DONE   = tv[k].done;
         tick();
      end
      TX_DONE = 1'b0; REQ_VALID = '0;

      // 4: watchdog (16) with TX_DONE withheld, then req1 served
      do_reset();
      REQ_VALID = 4'b0011; REQ_DATA = 32'h0000_4241; REQ_LAST = 4'b0011;
      tick();                                         // c1
      chk("t4_c1_grant", 32'(w_grant), 32'h1);
      tick();                                         // c2: WAIT entry
      chk("t4_c2_drdy", 32'(w_drdy), 32'h1);
      REQ_VALID = 4'b0010;
      repeat (15) tick();                             // c17
      chk("t4_c17_terr", 32'(w_terr), 32'h0);
      chk("t4_c17_grant", 32'(w_grant), 32'h1);
      tick();                                         // c18
      chk("t4_c18_terr", 32'(w_terr), 32'h1);
      chk("t4_c18_grant", 32'(w_grant), 32'h0);
      chk("t4_c18_busy", 32'(w_busy), 32'h0);
      tick();                                         // c19
      chk("t4_c19_terr", 32'(w_terr), 32'h0);
      chk("t4_c19_grant", 32'(w_grant), 32'h2);
      chk("t4_c19_ready", 32'(w_ready), 32'h2);
      tick();                                         // c20
      chk("t4_c20_drdy", 32'(w_drdy), 32'h1);
      chk("t4_c20_di", 32'(w_di), 32'h42);
      REQ_VALID = '0;

      // 5: owner drops VALID between bytes; req2 stalls until release
      do_reset();
      REQ_VALID = 4'b0101; REQ_DATA = 32'h0077_0031; REQ_LAST = 4'b0100;
      tick(); tick();                                 // c2
      chk("t5_c2_drdy", 32'(TX_DRDY), 32'h1);
      chk("t5_c2_di", 32'(TX_DI), 32'h31);
      REQ_VALID = 4'b0100;
      tick(); tick();                                 // c4
      TX_DONE = 1'b1;
      tick();                                         // c5
      TX_DONE = 1'b0;
      check_all("t5_c5", 4'h1, 4'h1, 1'b0, 8'h31, 1'b1, 1'b0);
      tick(); tick();                                 // c7: TX_DONE in ACCEPT
      TX_DONE = 1'b1;
      tick();                                         // c8
      TX_DONE = 1'b0;
      tick();                                         // c9
      check_all("t5_c9", 4'h1, 4'h1, 1'b0, 8'h31, 1'b1, 1'b0);
      REQ_VALID = 4'b0101; REQ_DATA = 32'h0077_0032; REQ_LAST = 4'b0101;
      tick();                                         // c10
      check_all("t5_c10", 4'h1, 4'h0, 1'b1, 8'h32, 1'b1, 1'b0);
      REQ_VALID = 4'b0100;
      tick();                                         // c11
      TX_DONE = 1'b1;
      tick();                                         // c12
      TX_DONE = 1'b0;
      chk("t5_c12_grant", 32'(GRANT), 32'h0);
      tick();                                         // c13
      chk("t5_c13_grant", 32'(GRANT), 32'h4);
      REQ_VALID = '0;

      // 6: reset one cycle after TX_DRDY; the late TX_DONE is ignored
      do_reset();
      REQ_VALID = 4'b0001; REQ_DATA = 32'h0000_005A; REQ_LAST = 4'b0001;
      tick(); tick();                                 // c2
      chk("t6_c2_drdy", 32'(TX_DRDY), 32'h1);
      REQ_VALID = '0;
      tick();                                         // c3
      RST = 1'b1;
      tick();                                         // c4
      RST = 1'b0;
      check_all("t6_c4", 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();                                         // c5
      TX_DONE = 1'b1;
      tick();                                         // c6
      TX_DONE = 1'b0;
      check_all("t6_c6", 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();                                         // c7
      chk("t6_c7_drdy", 32'(TX_DRDY), 32'h0);
      chk("t6_c7_grant", 32'(GRANT), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
